// File: rtl/dff_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dff_arb_pkg
// Purpose  : Shared types and default constants for the DFF write arbiter.
//            arb_state_t - arbiter FSM states (LOCKED is only reached when the
//                          design is built with ARB_LOCK_EN defined).
//            N_REQ_DEF   - default number of requesters.
//            WIDTH_DEF   - default width of the shared register.
// Revision : 1.0 - initial release
// ============================================================================
package dff_arb_pkg;

   localparam int N_REQ_DEF = 4;
   localparam int WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      LOCKED = 2'd2
   } arb_state_t;

endpackage : dff_arb_pkg
`default_nettype wire

// File: rtl/dff_write_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker. Returns the first set bit of
//            req, searching upward from ptr and wrapping N_REQ-1 -> 0.
// Ports    : req     [N_REQ-1:0] in  - request vector
//            ptr     [PTR_W-1:0] in  - search start index (always < N_REQ)
//            winner  [PTR_W-1:0] out - index of the selected requester
//            any_req             out - at least one request is pending
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
   import dff_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int PTR_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [PTR_W-1:0] winner,
   output logic             any_req
);

   always_comb begin
      int idx;
      idx     = 0;
      winner  = '0;
      any_req = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         // Wrap explicitly so non-power-of-2 N_REQ never indexes past the end.
         idx = int'(ptr) + i;
         if (idx >= N_REQ) begin
            idx = idx - N_REQ;
         end
         if (!any_req && req[idx]) begin
            any_req = 1'b1;
            winner  = PTR_W'(idx);
         end
      end
   end

endmodule : rr_pick
`default_nettype wire

// File: rtl/dff_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dff_write_arbiter
// Purpose  : Round-robin write arbiter owning one shared WIDTH-bit register.
//            A requester is granted for one cycle (IDLE -> GRANT); if it still
//            requests in that cycle its wdata slice is loaded into q.
// Ports    : clk, rst_n (sync, active-low)
//            req   [N_REQ-1:0]       in  - per-requester request
//            wdata [N_REQ*WIDTH-1:0] in  - per-requester write data
//            lock  [N_REQ-1:0]       in  - burst lock (ARB_LOCK_EN only)
//            gnt   [N_REQ-1:0]       out - registered one-hot grant
//            q / qbar [WIDTH-1:0]    out - shared register and its inverse
//            q_valid                 out - pulse after each register load
//            last_src                out - requester whose data is in q
// Config   : ARB_LOCK_EN - adds the lock port and the LOCKED burst state.
// Revision : 1.0 - initial release
// ============================================================================
module dff_write_arbiter
   import dff_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*WIDTH-1:0]   wdata,
`ifdef ARB_LOCK_EN
   input  logic [N_REQ-1:0]         lock,
`endif
   output logic [N_REQ-1:0]         gnt,
   output logic [WIDTH-1:0]         q,
   output logic [WIDTH-1:0]         qbar,
   output logic                     q_valid,
   output logic [$clog2(N_REQ)-1:0] last_src
);

   localparam int               PTR_W    = $clog2(N_REQ);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

   arb_state_t       state_q, state_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [PTR_W-1:0] win_q, win_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             q_valid_q, q_valid_d;
   logic [PTR_W-1:0] last_src_q, last_src_d;

   logic [PTR_W-1:0] pick_winner;
   logic             pick_any;
   logic [PTR_W-1:0] ptr_next;
   logic             hold_burst;

   rr_pick #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .req     (req),
      .ptr     (ptr_q),
      .winner  (pick_winner),
      .any_req (pick_any)
   );

   // Pointer always moves to the slot after the last granted requester,
   // whether or not its write actually happened.
   assign ptr_next = (win_q == LAST_IDX) ? '0 : win_q + PTR_W'(1);

   // A burst continues only while the owner keeps both req and lock high.
`ifdef ARB_LOCK_EN
   assign hold_burst = req[win_q] & lock[win_q];
`else
   assign hold_burst = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      win_d      = win_q;
      gnt_d      = gnt_q;
      q_d        = q_q;
      q_valid_d  = 1'b0;
      last_src_d = last_src_q;

      case (state_q)
         IDLE: begin
            gnt_d = '0;
            if (pick_any) begin
               win_d              = pick_winner;
               gnt_d[pick_winner] = 1'b1;
               state_d            = GRANT;
            end
         end

         GRANT: begin
            if (req[win_q]) begin
               q_d        = wdata[int'(win_q)*WIDTH +: WIDTH];
               last_src_d = win_q;
               q_valid_d  = 1'b1;
            end
            if (hold_burst) begin
               state_d = LOCKED;
            end else begin
               gnt_d   = '0;
               ptr_d   = ptr_next;
               state_d = IDLE;
            end
         end

         default: begin
            // LOCKED (only reachable with ARB_LOCK_EN); any other encoding
            // simply falls back to IDLE.
            if (hold_burst) begin
               q_d        = wdata[int'(win_q)*WIDTH +: WIDTH];
               last_src_d = win_q;
               q_valid_d  = 1'b1;
            end else begin
               gnt_d   = '0;
               ptr_d   = ptr_next;
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         win_q      <= '0;
         gnt_q      <= '0;
         q_q        <= '0;
         q_valid_q  <= 1'b0;
         last_src_q <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         win_q      <= win_d;
         gnt_q      <= gnt_d;
         q_q        <= q_d;
         q_valid_q  <= q_valid_d;
         last_src_q <= last_src_d;
      end
   end

   assign gnt      = gnt_q;
   assign q        = q_q;
   assign qbar     = ~q_q;
   assign q_valid  = q_valid_q;
   assign last_src = last_src_q;

endmodule : dff_write_arbiter
`default_nettype wire

// File: tb/tb_dff_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dff_write_arbiter
// Purpose  : Directed self-checking bench for dff_write_arbiter (N_REQ=4,
//            WIDTH=8). Inputs change and outputs are sampled 1 time unit
//            after each rising clock edge.
// Config   : ARB_LOCK_EN - also exercises the locked burst.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dff_write_arbiter;

   localparam int N_REQ = 4;
   localparam int WIDTH = 8;

   logic                   clk;
   logic                   rst_n;
   logic [N_REQ-1:0]       req;
   logic [N_REQ*WIDTH-1:0] wdata;
`ifdef ARB_LOCK_EN
   logic [N_REQ-1:0]       lock;
`endif
   logic [N_REQ-1:0]       gnt;
   logic [WIDTH-1:0]       q;
   logic [WIDTH-1:0]       qbar;
   logic                   q_valid;
   logic [1:0]             last_src;

   int checks;
   int errors;

   dff_write_arbiter #(
      .N_REQ (N_REQ),
      .WIDTH (WIDTH)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .wdata    (wdata),
`ifdef ARB_LOCK_EN
      .lock     (lock),
`endif
      .gnt      (gnt),
      .q        (q),
      .qbar     (qbar),
      .q_valid  (q_valid),
      .last_src (last_src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      req    = '0;
      wdata  = '0;
`ifdef ARB_LOCK_EN
      lock   = '0;
`endif

      // ---------------- reset ----------------
      tick();
      tick();
      check_eq("rst_q",        32'(q),        32'h00);
      check_eq("rst_qbar",     32'(qbar),     32'hFF);
      check_eq("rst_gnt",      32'(gnt),      32'h0);
      check_eq("rst_qvalid",   32'(q_valid),  32'h0);
      check_eq("rst_last_src", 32'(last_src), 32'h0);
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         check_eq("idle_gnt",    32'(gnt),     32'h0);
         check_eq("idle_qvalid", 32'(q_valid), 32'h0);
      end

      // ---------------- single request ----------------
      req = 4'b0100;
      wdata[2*WIDTH +: WIDTH] = 8'hA5;
      tick();
      check_eq("single_gnt",    32'(gnt),     32'h4);
      check_eq("single_qv0",    32'(q_valid), 32'h0);
      check_eq("single_q_pre",  32'(q),       32'h00);
      tick();
      check_eq("single_q",      32'(q),        32'hA5);
      check_eq("single_qbar",   32'(qbar),     32'h5A);
      check_eq("single_src",    32'(last_src), 32'h2);
      check_eq("single_qv1",    32'(q_valid),  32'h1);
      check_eq("single_gnt_off",32'(gnt),      32'h0);
      req = '0;
      tick();
      check_eq("single_qv_end", 32'(q_valid),  32'h0);

      // ---------------- reset mid-GRANT ----------------
      // ptr is now 3; requester 1 is the only one asking, so it wins.
      req = 4'b0010;
      wdata[1*WIDTH +: WIDTH] = 8'h77;
      tick();
      check_eq("midrst_gnt",   32'(gnt),      32'h2);
      rst_n = 1'b0;
      tick();
      check_eq("midrst_q",     32'(q),        32'h00);
      check_eq("midrst_gnt0",  32'(gnt),      32'h0);
      check_eq("midrst_qv",    32'(q_valid),  32'h0);
      check_eq("midrst_src",   32'(last_src), 32'h0);

      // ---------------- fairness (also proves ptr reset to 0) ----------
      rst_n = 1'b1;
      req   = 4'b1111;
      for (int i = 0; i < N_REQ; i++) wdata[i*WIDTH +: WIDTH] = 8'(8'h10 + i);
      for (int i = 0; i < N_REQ; i++) begin
         tick();
         check_eq("fair_gnt",    32'(gnt),      32'(1 << i));
         check_eq("fair_qv_gnt", 32'(q_valid),  32'h0);
         tick();
         check_eq("fair_q",      32'(q),        32'(8'h10 + i));
         check_eq("fair_src",    32'(last_src), 32'(i));
         check_eq("fair_qv",     32'(q_valid),  32'h1);
         check_eq("fair_gnt0",   32'(gnt),      32'h0);
      end
      req = '0;
      tick();

      // ---------------- abort ----------------
      req = 4'b0010;
      wdata[1*WIDTH +: WIDTH] = 8'hEE;
      tick();
      check_eq("abort_gnt",    32'(gnt),      32'h2);
      req = '0;
      tick();
      check_eq("abort_q",      32'(q),        32'h13);
      check_eq("abort_src",    32'(last_src), 32'h3);
      check_eq("abort_qv",     32'(q_valid),  32'h0);
      check_eq("abort_gnt0",   32'(gnt),      32'h0);
      // ptr must have moved past requester 1 even though it did not write.
      req = 4'b0110;
      tick();
      check_eq("abort_next",   32'(gnt),      32'h4);
      tick();
      check_eq("abort_next_q", 32'(q),        32'h12);
      req = '0;
      tick();

`ifdef ARB_LOCK_EN
      // ---------------- locked burst (ptr is now 3) ----------------
      req  = 4'b1000;
      lock = 4'b1000;
      wdata[3*WIDTH +: WIDTH] = 8'h01;
      tick();
      check_eq("lock_gnt",     32'(gnt), 32'h8);
      for (int i = 1; i <= 4; i++) begin
         tick();
         check_eq("lock_q",      32'(q),        32'(i));
         check_eq("lock_gnt_hold", 32'(gnt),    32'h8);
         check_eq("lock_qv",     32'(q_valid),  32'h1);
         wdata[3*WIDTH +: WIDTH] = 8'(i + 1);
      end
      lock = '0;
      tick();
      check_eq("unlock_gnt",   32'(gnt),      32'h0);
      check_eq("unlock_q",     32'(q),        32'h04);
      check_eq("unlock_qv",    32'(q_valid),  32'h0);
      req = 4'b1111;
      tick();
      check_eq("unlock_next",  32'(gnt),      32'h1);
      req = '0;
      tick();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_dff_write_arbiter
`default_nettype wire

// File: doc/dff_write_arbiter.md
# dff_write_arbiter

Round-robin write arbiter that shares one WIDTH-bit D-flip-flop register between N_REQ requesters. Each requester raises a request with its data. The arbiter grants one requester at a time and loads that requester's data into the shared register, which drives q and qbar. It sits between the requester blocks and the shared storage, and it is the only block allowed to write that register.

## Interface
- N_REQ, 4, number of requesters; legal values are 2 to 16
- WIDTH, 8, width of the shared register
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk
- req  input  N_REQ  request per requester; bit i belongs to requester i
- wdata  input  N_REQ*WIDTH  write data; slice [i*WIDTH +: WIDTH] belongs to requester i
- lock  input  N_REQ  burst-lock request per requester; present only with ARB_LOCK_EN
- gnt  output  N_REQ  registered one-hot grant; all zero when idle
- q  output  WIDTH  shared register contents
- qbar  output  WIDTH  combinational ~q
- q_valid  output  1  single-cycle pulse, one cycle after each register load
- last_src  output  $clog2(N_REQ)  index of the requester whose data is in q

## Operation
- States: IDLE, GRANT, LOCKED. LOCKED is present only with ARB_LOCK_EN.
- IDLE, any req bit set:
  - winner = first set bit of req, searching from ptr upward and wrapping N_REQ-1 to 0.
  - gnt <= onehot(winner); state <= GRANT.
- IDLE, req all zero: gnt stays 0; state stays IDLE.
- GRANT, req[winner] still high:
  - q <= wdata[winner]; last_src <= winner; q_valid <= 1.
  - ptr <= (winner+1) mod N_REQ.
- GRANT, req[winner] dropped: the write is aborted. q, last_src and q_valid are unchanged. ptr still advances.
- Leaving GRANT: gnt <= 0 and state <= IDLE, except for the lock case below.
- Only the granted requester's slice of wdata is ever sampled. Other req changes during GRANT are ignored until the next IDLE arbitration.
- ptr is $clog2(N_REQ) bits and wraps modulo N_REQ, including for non-power-of-2 N_REQ.
- Requesters hold req and wdata stable until they see gnt high. After that they may deassert.

## Timing
- Reset values: q=0, qbar=all ones, gnt=0, q_valid=0, last_src=0, ptr=0, state=IDLE.
- Reset takes priority over all other activity, including mid-GRANT or mid-LOCKED. No write completes on the reset edge.
- Request latency:
  - req high before edge k gives gnt high after edge k.
  - q is loaded at edge k+1; q_valid is high during cycle k+2.
- gnt is high for exactly one cycle per non-locked grant.
- Throughput: at most one non-locked write every 2 cycles.
- With all requesters asserting continuously, grants rotate 0,1,...,N_REQ-1,0,... with no starvation. Worst-case wait is 2*(N_REQ-1) cycles.
- qbar follows q with no register stage.

## Configuration
- Macro: ARB_LOCK_EN.
- Defined:
  - The lock port exists.
  - If lock[winner] is high in GRANT, the write happens as normal, gnt is held and state goes to LOCKED.
  - In LOCKED, q <= wdata[winner] every cycle and q_valid is high each following cycle, while req[winner] and lock[winner] are both high.
  - When either req[winner] or lock[winner] drops, that cycle performs no write, gnt goes to 0, ptr advances and state goes to IDLE.
- Undefined: the lock port and the LOCKED state are absent; every grant lasts one cycle.

## Structure
- Package dff_arb_pkg holds:
  - the state enum arb_state_t (IDLE, GRANT, LOCKED);
  - the default constants N_REQ_DEF=4 and WIDTH_DEF=8.
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: req, ptr. Outputs: winner index, any_req.
  - Instantiated once.

## Test plan
- Reset with rst_n=0 for 2 cycles, then release with req=0: q=0x00, qbar=0xFF, gnt=0, q_valid never pulses.
- Single request: req=4'b0100, wdata[2]=0xA5 → gnt=4'b0100 for one cycle, q=0xA5 and qbar=0x5A one cycle later, last_src=2, q_valid pulse.
- Fairness: req=4'b1111 held for 8 cycles, wdata[i]=0x10+i → grant order 0,1,2,3, q sequence 0x10,0x11,0x12,0x13, every other cycle.
- Abort: requester 1 drops req during its GRANT cycle → q and last_src keep their previous values, no q_valid, and the next grant goes to requester 2 or later.
- Reset mid-operation: rst_n=0 during GRANT → no write, q=0, gnt=0, ptr=0; the next grant starts from requester 0.
- With ARB_LOCK_EN: req[3] and lock[3] high for 4 cycles, wdata[3] incrementing 0x01..0x04 → gnt stays 4'b1000 throughout, q follows 0x01..0x04 each cycle; dropping lock[3] returns the arbiter to IDLE and the next grant goes to requester 0.
